// File: rtl/posit_weight_serializer_if.sv
`default_nettype none
// posit_weight_serializer_if: config, parallel-word and serial-stream signals
// of the posit weight serializer. Rev 1.0
interface posit_weight_serializer_if #(
  parameter int MAX_PREC   = 8,
  parameter int PREC_WIDTH = 4
);
  logic                  cfg_set;
  logic [PREC_WIDTH-1:0] cfg_prec;
  logic                  cfg_ready;
  logic [MAX_PREC-1:0]   w_in;
  logic                  w_in_valid;
  logic                  w_in_ready;
  logic                  w;
  logic                  valid;
  logic                  last;
  logic                  set;
  logic [PREC_WIDTH-1:0] precision;

  modport master (
    output cfg_set, cfg_prec, w_in, w_in_valid,
    input  cfg_ready, w_in_ready, w, valid, last, set, precision
  );

  modport slave (
    input  cfg_set, cfg_prec, w_in, w_in_valid,
    output cfg_ready, w_in_ready, w, valid, last, set, precision
  );
endinterface
`default_nettype wire

// File: rtl/posit_weight_serializer.sv
`default_nettype none
// posit_weight_serializer: MSB-first bit-serial transmitter for posit weights
// with a one-cycle precision pulse and a holding register for gapless words. Rev 1.0
module posit_weight_serializer #(
  parameter int MAX_PREC   = 8,
  parameter int PREC_WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  posit_weight_serializer_if.slave bus
);
  localparam logic [PREC_WIDTH-1:0] PREC_MAX = PREC_WIDTH'(MAX_PREC);
  localparam logic [PREC_WIDTH-1:0] PREC_MIN = PREC_WIDTH'(2);
  localparam logic [PREC_WIDTH-1:0] PREC_ONE = PREC_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [MAX_PREC-1:0]   shreg;
  logic [MAX_PREC-1:0]   hold_data;
  logic [MAX_PREC-1:0]   load_word;
  logic [PREC_WIDTH-1:0] count;
  logic [PREC_WIDTH-1:0] prec_active;
  logic [PREC_WIDTH-1:0] prec_clamped;
  logic                  hold_valid;
  logic                  cfg_go;
  logic                  drain;
  logic                  take;
  logic                  load;
  logic                  shift_done;
  logic                  in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    drain      = 1'b0;
    shift_done = (state == SHIFT) && (count == '0);
    // Configuration has priority over any word waiting in IDLE.
    cfg_go     = (state == IDLE) && !hold_valid && bus.cfg_set;
    case (state)
      IDLE:    drain = hold_valid;
      SHIFT:   drain = shift_done && hold_valid;
      default: drain = 1'b0;
    endcase
    in_ready = (state != CFG) && !cfg_go && (!hold_valid || drain);
    take     = bus.w_in_valid && in_ready;
    // Without a held word, an accepted word bypasses straight into the shifter.
    load     = drain || (take && !hold_valid && ((state == IDLE) || shift_done));
    case (state)
      IDLE: begin
        if (cfg_go) begin
          state_n = CFG;
        end else if (load) begin
          state_n = SHIFT;
        end
      end
      CFG:     state_n = IDLE;
      SHIFT: begin
        if (shift_done && !load) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    prec_clamped = bus.cfg_prec;
    if (bus.cfg_prec < PREC_MIN) begin
      prec_clamped = PREC_MIN;
    end else if (bus.cfg_prec > PREC_MAX) begin
      prec_clamped = PREC_MAX;
    end
  end

  // Left-align the posit so its MSB sits at the top of the shifter.
  assign load_word = (drain ? hold_data : bus.w_in) << (PREC_MAX - prec_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      hold_data   <= '0;
      hold_valid  <= 1'b0;
      count       <= '0;
      prec_active <= PREC_MAX;
    end else begin
      if (cfg_go) begin
        prec_active <= prec_clamped;
      end
      if (load) begin
        shreg <= load_word;
        count <= prec_active - PREC_ONE;
      end else if (state == SHIFT) begin
        shreg <= {shreg[MAX_PREC-2:0], 1'b0};
        count <= count - PREC_ONE;
      end
      if (take && !(load && !drain)) begin
        hold_data  <= bus.w_in;
        hold_valid <= 1'b1;
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.cfg_ready  = (state == IDLE) && !hold_valid;
  assign bus.w_in_ready = in_ready;
  assign bus.valid      = (state == SHIFT);
  assign bus.w          = (state == SHIFT) && shreg[MAX_PREC-1];
  assign bus.last       = (state == SHIFT) && (count == '0);
  assign bus.set        = (state == CFG);
  assign bus.precision  = prec_active;

endmodule
`default_nettype wire

// File: tb/tb_posit_weight_serializer.sv
`default_nettype none
// tb_posit_weight_serializer: scoreboard bench for the posit weight serializer. Rev 1.0
module tb_posit_weight_serializer;
  localparam int MAX_PREC   = 8;
  localparam int PREC_WIDTH = 4;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  posit_weight_serializer_if #(.MAX_PREC(MAX_PREC), .PREC_WIDTH(PREC_WIDTH)) bus ();

  posit_weight_serializer #(.MAX_PREC(MAX_PREC), .PREC_WIDTH(PREC_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int p);
    if (p < 2) return 2;
    if (p > MAX_PREC) return MAX_PREC;
    return p;
  endfunction

  // Scoreboard entries are {w, last}.
  logic [1:0] q[$];
  logic [1:0] e;
  int  model_prec = MAX_PREC;
  int  pend_prec  = 0;
  bit  pend       = 0;
  bit  exp_set    = 0;
  int  cyc        = 0;
  int  run        = 0;
  int  last_run   = 0;
  int  first_cyc  = 0;
  int  set_cyc    = 0;
  int  stall      = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pend       = 0;
      exp_set    = 0;
      model_prec = MAX_PREC;
      run        = 0;
    end else begin
      cyc++;
      exp_set = pend;
      if (pend) model_prec = pend_prec;
      pend = 0;
      check("set", 32'(bus.set), 32'(exp_set));
      check("precision", 32'(bus.precision), 32'(model_prec));
      if (bus.set) set_cyc = cyc;
      if (bus.valid) begin
        if (run == 0) first_cyc = cyc;
        run++;
        if (q.size() == 0) begin
          check("spurious_valid", 32'(bus.valid), 32'(0));
        end else begin
          e = q.pop_front();
          check("w", 32'(bus.w), 32'(e[1]));
          check("last", 32'(bus.last), 32'(e[0]));
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        check("idle_w_last", 32'({bus.w, bus.last}), 32'(0));
      end
      if (bus.w_in_valid && !bus.w_in_ready) stall++;
      if (bus.cfg_set && bus.cfg_ready) begin
        pend      = 1;
        pend_prec = clamp(int'(bus.cfg_prec));
      end
      if (bus.w_in_valid && bus.w_in_ready) begin
        for (int i = model_prec - 1; i >= 0; i--) q.push_back({bus.w_in[i], i == 0});
      end
    end
  end

  task automatic do_cfg(input int p);
    bus.cfg_set  = 1'b1;
    bus.cfg_prec = PREC_WIDTH'(p);
    @(posedge clk); #1;
    bus.cfg_set  = 1'b0;
  endtask

  task automatic offer(input logic [7:0] word);
    bit acc = 0;
    int n   = 0;
    bus.w_in       = word;
    bus.w_in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.w_in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("offer_accepted", 32'(acc), 32'(1));
  endtask

  task automatic drain_out;
    int n = 0;
    bus.w_in_valid = 1'b0;
    while ((q.size() != 0 || bus.valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int stall_base;

  initial begin
    rst            = 1'b1;
    bus.cfg_set    = 1'b0;
    bus.cfg_prec   = '0;
    bus.w_in       = '0;
    bus.w_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_outs", 32'({bus.w, bus.valid, bus.last, bus.set}), 32'(0));
    check("rst_prec", 32'(bus.precision), 32'(MAX_PREC));
    check("rst_ready", 32'({bus.w_in_ready, bus.cfg_ready}), 32'(3));
    @(posedge clk); #1;

    // Configuration pulse
    do_cfg(4);
    check("cfg_set_pulse", 32'(bus.set), 32'(1));
    check("cfg_prec4", 32'(bus.precision), 32'(4));
    @(posedge clk); #1;
    check("cfg_set_done", 32'({bus.set, bus.cfg_ready}), 32'(1));

    // Single word, first bit one cycle after acceptance
    offer(8'h0B);
    bus.w_in_valid = 1'b0;
    @(negedge clk);
    check("latency_first", 32'(bus.valid), 32'(1));
    drain_out();

    // Back-to-back words with the holding register filling up
    stall_base = stall;
    offer(8'h0A);
    offer(8'h05);
    offer(8'h0C);
    drain_out();
    check("b2b_stall", 32'(stall - stall_base), 32'(2));
    check("b2b_run", 32'(last_run), 32'(12));

    // Clamping; upper word bits beyond prec are ignored
    do_cfg(0);
    check("clamp_lo", 32'(bus.precision), 32'(2));
    @(posedge clk); #1;
    offer(8'hFE);
    drain_out();
    check("clamp_lo_run", 32'(last_run), 32'(2));
    do_cfg(12);
    check("clamp_hi", 32'(bus.precision), 32'(8));
    @(posedge clk); #1;

    // cfg_set while shifting is ignored
    offer(8'hC3);
    bus.w_in_valid = 1'b0;
    @(posedge clk); #1;
    check("cfg_ready_busy", 32'(bus.cfg_ready), 32'(0));
    bus.cfg_set  = 1'b1;
    bus.cfg_prec = 4'd3;
    @(posedge clk); #1;
    bus.cfg_set  = 1'b0;
    @(negedge clk);
    check("busy_no_set", 32'(bus.set), 32'(0));
    check("busy_prec", 32'(bus.precision), 32'(8));
    drain_out();

    // Reset in the middle of a word
    offer(8'hA5);
    bus.w_in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", 32'({bus.w, bus.valid, bus.last, bus.set}), 32'(0));
    check("rst_mid_ready", 32'({bus.w_in_ready, bus.cfg_ready}), 32'(3));
    check("rst_mid_prec", 32'(bus.precision), 32'(MAX_PREC));
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    offer(8'h3C);
    drain_out();
    check("post_rst_run", 32'(last_run), 32'(8));

    // Simultaneous cfg_set and word in IDLE
    stall_base     = stall;
    bus.cfg_set    = 1'b1;
    bus.cfg_prec   = 4'd5;
    bus.w_in       = 8'h16;
    bus.w_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_set    = 1'b0;
    offer(8'h16);
    drain_out();
    check("sim_gap", 32'(first_cyc - set_cyc), 32'(2));
    check("sim_stall", 32'(stall - stall_base), 32'(2));
    check("sim_run", 32'(last_run), 32'(5));
    check("sim_prec", 32'(bus.precision), 32'(5));

    check("queue_empty", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/posit_weight_serializer.md
Name: posit_weight_serializer

Overview:
- Transmit side of the bit-serial posit weight interface consumed by fp_posit_mul (inputs w, valid, set, precision).
- Accepts parallel posit weight words and emits them MSB-first, one bit per clock, with a one-cycle precision-configuration pulse ahead of the stream.
- Two-deep buffering (holding register plus shift register) allows back-to-back words with no bubble cycles.
- Sits between the weight buffer/loader and the fp_posit_mul array.

Parameters:
- MAX_PREC, 8, widest supported posit weight in bits; legal range 2..15.
- PREC_WIDTH, 4, width of the precision fields.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_set  input  1  request to load a new precision.
- cfg_prec  input  PREC_WIDTH  requested precision in bits.
- cfg_ready  output  1  high only in IDLE with an empty buffer; cfg_set is accepted only when this is high.
- w_in  input  MAX_PREC  weight word; the posit occupies w_in[prec-1:0].
- w_in_valid  input  1  w_in is valid.
- w_in_ready  output  1  holding register can accept a word.
- w  output  1  serial weight bit; registered.
- valid  output  1  w carries a weight bit this cycle.
- last  output  1  w is the final (LSB) bit of the current word.
- set  output  1  one-cycle configuration pulse to the multiplier.
- precision  output  PREC_WIDTH  active precision; stable except when updated with set.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, buffers empty, active precision=MAX_PREC.
  - Outputs: w=0, valid=0, last=0, set=0, precision=MAX_PREC, w_in_ready=1, cfg_ready=1.
  - Reset mid-word discards the partial word and any held word immediately; no last is emitted.
- States:
  - IDLE: nothing shifting.
    - cfg_set=1 goes to CFG.
    - Otherwise, when the holding register or incoming word is available, load the shift register and go to SHIFT.
  - CFG (exactly 1 cycle): set=1, precision=clamped cfg_prec, valid=0; then return to IDLE.
  - SHIFT: one bit per cycle for prec cycles.
    - After the final bit: if the holding register is full (or a word is accepted that same cycle), reload and stay in SHIFT with no gap; otherwise go to IDLE.
- Clamp rule: precision values below 2 become 2; values above MAX_PREC become MAX_PREC. The clamp is applied at CFG.
- cfg_set when cfg_ready=0: ignored, with no side effects. If cfg_set and w_in_valid are both high in IDLE, configuration wins and the word waits; w_in_ready is forced 0 during that cycle.
- Word handshake:
  - A word transfers when w_in_valid & w_in_ready.
  - w_in_ready = holding register empty, or the holding register drains into the shift register this cycle.
  - w_in_ready is 0 during CFG.
  - w_in bits at or above prec are ignored.
- Latency: a word accepted into an empty block in cycle N presents bit prec-1 on w in cycle N+1 with valid=1. Bit 0 appears in cycle N+prec with last=1.
- Counter: a bit counter loads prec-1 and decrements per shifted bit; last = valid & (count==0).
- Throughput: sustained 1 bit/cycle. Continuous valid across words, with last marking each boundary.
- Precision is sampled per word at shift-register load. A word in flight always completes at the precision it started with.
- valid=0 cycles: w=0, last=0.

Test Plan:
- Reset, cfg_set=1 with cfg_prec=4 for 1 cycle -> one cycle later set=1, precision=4; set=0 thereafter; cfg_ready returns to 1.
- precision=4, send w_in=8'h0B -> w sequence 1,0,1,1 on 4 consecutive cycles with valid=1; last=1 only on the 4th bit; first bit 1 cycle after acceptance.
- precision=4, offer words 8'h0A then 8'h05 with w_in_valid held -> w = 1,0,1,0,0,1,0,1 with valid continuously high and last on bits 4 and 8; w_in_ready drops while the holding register is full.
- cfg_prec=0 -> precision=2; cfg_prec=12 with MAX_PREC=8 -> precision=8. cfg_set during SHIFT -> ignored; precision is unchanged and no set pulse is produced.
- Assert rst during bit 2 of an 8-bit word -> valid, last, set and w go to 0 immediately; after release, cfg_ready=1 and w_in_ready=1, and the next word streams from its MSB.
- Simultaneous cfg_set and w_in_valid in IDLE -> set pulse first; the word then streams at the new precision beginning 2 cycles later.
